// File: rtl/dec_subkey_feeder.sv
// Serpent decryption round-key buffer: captures K0..K32 in encryption order and
// replays them K32..K0 over a valid/ready port. Optional DEC_KEY_ZEROIZE_EN macro
// adds a ZERO state that wipes the key storage after clear or rst.
module dec_subkey_feeder #(
  parameter int NUM_KEYS = 33,
  parameter int KEY_W    = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [KEY_W-1:0] load_key,
  input  logic             clear,
  input  logic             start,
  output logic             key_valid,
  input  logic             key_ready,
  output logic [KEY_W-1:0] key_out,
  output logic [5:0]       key_idx,
  output logic             busy,
  output logic             done
);

  localparam logic [5:0] LAST_IDX = 6'(NUM_KEYS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FULL,
    STREAM,
    ZERO
  } state_e;

  state_e           state_q, state_d;
  logic [5:0]       wr_cnt_q, wr_cnt_d;
  logic [5:0]       rd_idx_q, rd_idx_d;
  logic             load_ready_q, load_ready_d;
  logic             key_valid_q, key_valid_d;
  logic [KEY_W-1:0] key_out_q, key_out_d;
  logic [5:0]       key_idx_q, key_idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [KEY_W-1:0] mem [NUM_KEYS];
  logic             mem_we;
  logic [5:0]       mem_waddr;
  logic [KEY_W-1:0] mem_wdata;

  logic             load_accept;
  logic             key_fire;
  logic [5:0]       rd_prev;

  assign load_accept = load_valid && load_ready_q;
  assign key_fire    = key_valid_q && key_ready;
  assign rd_prev     = rd_idx_q - 6'd1;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_idx_d    = rd_idx_q;
    key_valid_d = key_valid_q;
    key_out_d   = key_out_q;
    key_idx_d   = key_idx_q;
    done_d      = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = wr_cnt_q;
    mem_wdata   = load_key;

    if (clear && (state_q != ZERO)) begin
`ifdef DEC_KEY_ZEROIZE_EN
      state_d = ZERO;
`else
      state_d = IDLE;
`endif
      wr_cnt_d    = '0;
      rd_idx_d    = LAST_IDX;
      key_valid_d = 1'b0;
      key_idx_d   = LAST_IDX;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_accept) begin
            mem_we   = 1'b1;
            wr_cnt_d = wr_cnt_q + 6'd1;
            state_d  = LOAD;
          end
        end

        LOAD: begin
          if (load_accept) begin
            mem_we = 1'b1;
            // The counter parks at the last index once storage is full.
            if (wr_cnt_q == LAST_IDX) begin
              state_d = FULL;
            end else begin
              wr_cnt_d = wr_cnt_q + 6'd1;
            end
          end
        end

        FULL: begin
          if (start) begin
            state_d     = STREAM;
            rd_idx_d    = LAST_IDX;
            key_valid_d = 1'b1;
            key_out_d   = mem[LAST_IDX];
            key_idx_d   = LAST_IDX;
          end
        end

        STREAM: begin
          if (key_fire) begin
            if (rd_idx_q == 6'd0) begin
              state_d     = FULL;
              done_d      = 1'b1;
              rd_idx_d    = LAST_IDX;
              key_valid_d = 1'b0;
              key_idx_d   = LAST_IDX;
            end else begin
              rd_idx_d  = rd_prev;
              key_out_d = mem[rd_prev];
              key_idx_d = rd_prev;
            end
          end
        end

`ifdef DEC_KEY_ZEROIZE_EN
        ZERO: begin
          mem_we    = 1'b1;
          mem_wdata = '0;
          if (wr_cnt_q == LAST_IDX) begin
            state_d  = IDLE;
            wr_cnt_d = '0;
          end else begin
            wr_cnt_d = wr_cnt_q + 6'd1;
          end
        end
`endif

        default: begin
          state_d  = IDLE;
          wr_cnt_d = '0;
          rd_idx_d = LAST_IDX;
        end
      endcase
    end

    load_ready_d = (state_d == IDLE) || (state_d == LOAD);
    busy_d       = (state_d == LOAD) || (state_d == STREAM) || (state_d == ZERO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef DEC_KEY_ZEROIZE_EN
      state_q      <= ZERO;
      load_ready_q <= 1'b0;
      busy_q       <= 1'b1;
`else
      state_q      <= IDLE;
      load_ready_q <= 1'b1;
      busy_q       <= 1'b0;
`endif
      wr_cnt_q    <= '0;
      rd_idx_q    <= LAST_IDX;
      key_valid_q <= 1'b0;
      key_out_q   <= '0;
      key_idx_q   <= LAST_IDX;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_idx_q     <= rd_idx_d;
      load_ready_q <= load_ready_d;
      key_valid_q  <= key_valid_d;
      key_out_q    <= key_out_d;
      key_idx_q    <= key_idx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // NOTE: key storage has no reset; contents are only meaningful after a full load.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign load_ready = load_ready_q;
  assign key_valid  = key_valid_q;
  assign key_out    = key_out_q;
  assign key_idx    = key_idx_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
